// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: store/load size encodings and lane byte-enable helper.
// Used by both the store lane buffer and the load-extract unit.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Little-endian lanes: byte at addr[1:0]=k lives in lane k.
    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store narrowing: replicates the low data bits across lanes, builds byte
// enables and flags misaligned or reserved-size requests.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        bad_o
);

    always_comb begin
        wdata_o = data_i;
        bad_o   = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
            end
            SIZE_HALF: begin
                wdata_o = {2{data_i[15:0]}};
                bad_o   = addr_lo_i[0];
            end
            SIZE_WORD: begin
                wdata_o = data_i;
                bad_o   = (addr_lo_i != 2'b00);
            end
            default: begin
                wdata_o = data_i;
                bad_o   = 1'b1;
            end
        endcase
    end

    assign be_o = f_byte_en(size_i, addr_lo_i);

endmodule

// File: rtl/store_lane_buffer.sv
// MEM-stage store queue: accepts aligned stores, holds them in a small FIFO and drains them
// to data memory in order over a req/ack handshake.
module store_lane_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [1:0]    size_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   data_i,
    output logic          ready_o,
    output logic          misalign_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_ack_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [AW-3:0] addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];

    ptr_t wr_ptr_q, rd_ptr_q;
    cnt_t count_q,  count_d;
    logic misalign_q;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        lane_bad;
    logic        push, pop;

    store_lane_align u_align (
        .size_i    (size_i),
        .addr_lo_i (addr_i[1:0]),
        .data_i    (data_i),
        .wdata_o   (lane_wdata),
        .be_o      (lane_be),
        .bad_o     (lane_bad)
    );

    // Ready depends only on the registered count, so a same-cycle ack never frees a slot.
    assign ready_o   = (count_q < cnt_t'(DEPTH));
    assign mem_req_o = (count_q != '0);

    assign push = valid_i & ready_o & ~lane_bad;
    assign pop  = mem_req_o & mem_ack_i;

    always_comb begin
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
        end else begin
            count_q    <= count_d;
            misalign_q <= valid_i & ready_o & lane_bad;
            if (push) begin
                addr_q[wr_ptr_q]  <= addr_i[AW-1:2];
                wdata_q[wr_ptr_q] <= lane_wdata;
                be_q[wr_ptr_q]    <= lane_be;
                wr_ptr_q          <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
        end
    end

    assign misalign_o  = misalign_q;
    assign mem_addr_o  = {addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata_o = wdata_q[rd_ptr_q];
    assign mem_be_o    = be_q[rd_ptr_q];

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer: lane narrowing, rejection, back-pressure, drain order
// and asynchronous reset abort.
module tb_store_lane_buffer;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;

    int n_checks;
    int n_fails;

    store_lane_buffer #(
        .DEPTH (2),
        .AW    (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .size_i      (size_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .misalign_o  (misalign_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        valid_i = v;
        size_i  = sz;
        addr_i  = a;
        data_i  = d;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_i     = 1'b0;
        mem_ack_i = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #12;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_be", {28'b0, mem_be_o}, 32'h0);
        rst_i = 1'b1;
        tick();

        // SB to lane 3
        drive(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5);
        chk("sb_ready", {31'b0, ready_o}, 32'd1);
        chk("sb_req_before", {31'b0, mem_req_o}, 32'd0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sb_req", {31'b0, mem_req_o}, 32'd1);
        chk("sb_be", {28'b0, mem_be_o}, 32'h8);
        chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_addr", mem_addr_o, 32'h0000_1000);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("sb_drained", {31'b0, mem_req_o}, 32'd0);

        // SH upper half, then misaligned SH
        drive(1'b1, 2'b01, 32'h0000_2002, 32'hFFFF_1234);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sh_be", {28'b0, mem_be_o}, 32'hC);
        chk("sh_wdata", mem_wdata_o, 32'h1234_1234);
        chk("sh_addr", mem_addr_o, 32'h0000_2000);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        drive(1'b1, 2'b01, 32'h0000_2001, 32'hFFFF_1234);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sh_mis_pulse", {31'b0, misalign_o}, 32'd1);
        chk("sh_mis_noreq", {31'b0, mem_req_o}, 32'd0);
        tick();
        chk("sh_mis_end", {31'b0, misalign_o}, 32'd0);
        chk("sh_mis_count", 32'(dut.count_q), 32'd0);

        // Fill with SW, third request back-pressured, then drain in order
        drive(1'b1, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 2'b10, 32'h0000_3004, 32'h0102_0304);
        tick();
        drive(1'b1, 2'b10, 32'h0000_3008, 32'hCAFE_F00D);
        chk("sw_full_ready", {31'b0, ready_o}, 32'd0);
        chk("sw_full_count", 32'(dut.count_q), 32'd2);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sw_no_push", 32'(dut.count_q), 32'd2);
        chk("sw_head_addr", mem_addr_o, 32'h0000_3000);
        chk("sw_head_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_head_be", {28'b0, mem_be_o}, 32'hF);
        mem_ack_i = 1'b1;
        tick();
        chk("sw_second_addr", mem_addr_o, 32'h0000_3004);
        chk("sw_second_wdata", mem_wdata_o, 32'h0102_0304);
        chk("sw_second_count", 32'(dut.count_q), 32'd1);
        tick();
        mem_ack_i = 1'b0;
        chk("sw_empty_req", {31'b0, mem_req_o}, 32'd0);
        chk("sw_empty_count", 32'(dut.count_q), 32'd0);

        // Full FIFO with push and ack in the same cycle
        drive(1'b1, 2'b10, 32'h0000_4000, 32'h1111_1111);
        tick();
        drive(1'b1, 2'b10, 32'h0000_4004, 32'h2222_2222);
        tick();
        drive(1'b1, 2'b10, 32'h0000_4008, 32'h3333_3333);
        mem_ack_i = 1'b1;
        chk("full_ack_ready", {31'b0, ready_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        chk("full_ack_ready_next", {31'b0, ready_o}, 32'd1);
        chk("full_ack_count", 32'(dut.count_q), 32'd1);
        chk("full_ack_head", mem_addr_o, 32'h0000_4004);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("full_refill_count", 32'(dut.count_q), 32'd2);
        mem_ack_i = 1'b1;
        tick();
        chk("full_last_addr", mem_addr_o, 32'h0000_4008);
        chk("full_last_wdata", mem_wdata_o, 32'h3333_3333);
        tick();
        mem_ack_i = 1'b0;
        chk("full_drained", 32'(dut.count_q), 32'd0);

        // Reserved size, then ack with empty FIFO
        drive(1'b1, 2'b11, 32'h0000_0000, 32'h5555_5555);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("rsvd_pulse", {31'b0, misalign_o}, 32'd1);
        chk("rsvd_noreq", {31'b0, mem_req_o}, 32'd0);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("empty_ack_count", 32'(dut.count_q), 32'd0);
        chk("empty_ack_req", {31'b0, mem_req_o}, 32'd0);
        chk("empty_ack_ready", {31'b0, ready_o}, 32'd1);

        // Asynchronous reset with two entries queued
        drive(1'b1, 2'b10, 32'h0000_5000, 32'hAAAA_AAAA);
        tick();
        drive(1'b1, 2'b10, 32'h0000_5004, 32'hBBBB_BBBB);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("async_rst_count", 32'(dut.count_q), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, ready_o}, 32'd1);
        chk("post_rst_count", 32'(dut.count_q), 32'd0);
        chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
